pc_fetch_unit: RTL and testbench

Parametrised program-counter and instruction-fetch sequencer that replaces the free-running PC register of the single-cycle core. It owns the PC, issues one outstanding fetch request at a time to instruction memory over a valid/ready handshake, and hands the returned instruction plus its PC to decode. It accepts execute-stage (branch/jal/jalr) and trap/mret redirects at any point and discards stale in-flight responses.

---
 rtl/pcu_pkg.sv | 17 +
 rtl/pcu_hold_buf.sv | 39 +++
 rtl/pc_fetch_unit.sv | 110 +++++++++++
 tb/tb_pc_fetch_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcu_pkg.sv
// Shared definitions for the program-counter / instruction-fetch sequencer.
package pcu_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    DROP = 3'd4
  } pcu_state_e;

  localparam int          XLEN_DEF     = 64;
  localparam int          INST_W_DEF   = 32;
  localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
  localparam int          INST_BYTES   = 4;

endpackage

// File: rtl/pcu_hold_buf.sv
// Single-entry {pc, inst} buffer between the imem response and decode.
module pcu_hold_buf #(
  parameter int XLEN   = 64,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_inval,
  input  logic [XLEN-1:0]   i_pc,
  input  logic [INST_W-1:0] i_inst,
  output logic              o_valid,
  output logic [XLEN-1:0]   o_pc,
  output logic [INST_W-1:0] o_inst
);

  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [INST_W-1:0] r_inst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_inst  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_inst  <= i_inst;
    end else if (i_inval) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_inst  = r_inst;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC owner and single-outstanding instruction-fetch sequencer with
// execute/trap redirects and stale-response discard.
module pc_fetch_unit
  import pcu_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              INST_W   = INST_W_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ex_redir,
  input  logic [XLEN-1:0]   i_ex_target,
  input  logic              i_trap_redir,
  input  logic [XLEN-1:0]   i_trap_target,
  output logic              o_req_valid,
  input  logic              i_req_ready,
  output logic [XLEN-1:0]   o_req_addr,
  input  logic              i_rsp_valid,
  input  logic [INST_W-1:0] i_rsp_inst,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [XLEN-1:0]   o_out_pc,
  output logic [INST_W-1:0] o_out_inst,
  output logic              o_misalign,
  output logic [XLEN-1:0]   o_misalign_pc
);

  pcu_state_e      r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_misalign;
  logic [XLEN-1:0] r_misalign_pc;

  logic            w_redir;
  logic [XLEN-1:0] w_target;
  logic            w_accept;
  logic            w_misalign;
  logic            w_req_fire;
  logic            w_out_fire;
  logic            w_load;
  logic            w_inval;

  // Trap/mret wins over an execute redirect in the same cycle.
  assign w_redir    = i_trap_redir | i_ex_redir;
  assign w_target   = i_trap_redir ? i_trap_target : i_ex_target;
  assign w_accept   = w_redir & (w_target[1:0] == 2'b00);
  assign w_misalign = w_redir & (w_target[1:0] != 2'b00);

  assign w_req_fire = o_req_valid & i_req_ready;
  assign w_out_fire = o_out_valid & i_out_ready;
  assign w_load     = (r_state == WAIT) & i_rsp_valid & ~w_accept;
  assign w_inval    = (r_state == HOLD) & (w_accept | w_out_fire);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_misalign    <= 1'b0;
      r_misalign_pc <= '0;
    end else begin
      r_misalign <= w_misalign;
      if (w_misalign) r_misalign_pc <= w_target;

      if (w_accept)        r_pc <= w_target;
      else if (w_out_fire) r_pc <= r_pc + XLEN'(INST_BYTES);

      case (r_state)
        IDLE: r_state <= REQ;
        REQ: begin
          if (w_accept)        r_state <= w_req_fire ? DROP : REQ;
          else if (w_req_fire) r_state <= WAIT;
        end
        WAIT: begin
          if (w_accept)         r_state <= i_rsp_valid ? REQ : DROP;
          else if (i_rsp_valid) r_state <= HOLD;
        end
        HOLD: begin
          if (w_accept || w_out_fire) r_state <= REQ;
        end
        // The stale response retires the outstanding request even if a
        // further redirect lands in the same cycle.
        DROP: begin
          if (i_rsp_valid) r_state <= REQ;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  pcu_hold_buf #(
    .XLEN   (XLEN),
    .INST_W (INST_W)
  ) u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_inval (w_inval),
    .i_pc    (r_pc),
    .i_inst  (i_rsp_inst),
    .o_valid (o_out_valid),
    .o_pc    (o_out_pc),
    .o_inst  (o_out_inst)
  );

  assign o_req_valid   = (r_state == REQ);
  assign o_req_addr    = r_pc;
  assign o_misalign    = r_misalign;
  assign o_misalign_pc = r_misalign_pc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus a randomized run against
// a transaction-level model of the expected fetch/deliver stream.
module tb_pc_fetch_unit;

  localparam int          XLEN   = 64;
  localparam int          INST_W = 32;
  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_ex_redir;
  logic [XLEN-1:0]   i_ex_target;
  logic              i_trap_redir;
  logic [XLEN-1:0]   i_trap_target;
  logic              o_req_valid;
  logic              i_req_ready;
  logic [XLEN-1:0]   o_req_addr;
  logic              i_rsp_valid;
  logic [INST_W-1:0] i_rsp_inst;
  logic              o_out_valid;
  logic              i_out_ready;
  logic [XLEN-1:0]   o_out_pc;
  logic [INST_W-1:0] o_out_inst;
  logic              o_misalign;
  logic [XLEN-1:0]   o_misalign_pc;

  int n_checks = 0;
  int n_pass   = 0;

  pc_fetch_unit #(
    .XLEN     (XLEN),
    .INST_W   (INST_W),
    .RESET_PC (RST_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_ex_redir    (i_ex_redir),
    .i_ex_target   (i_ex_target),
    .i_trap_redir  (i_trap_redir),
    .i_trap_target (i_trap_target),
    .o_req_valid   (o_req_valid),
    .i_req_ready   (i_req_ready),
    .o_req_addr    (o_req_addr),
    .i_rsp_valid   (i_rsp_valid),
    .i_rsp_inst    (i_rsp_inst),
    .o_out_valid   (o_out_valid),
    .i_out_ready   (i_out_ready),
    .o_out_pc      (o_out_pc),
    .o_out_inst    (o_out_inst),
    .o_misalign    (o_misalign),
    .o_misalign_pc (o_misalign_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    i_ex_redir    = 1'b0;
    i_ex_target   = '0;
    i_trap_redir  = 1'b0;
    i_trap_target = '0;
    i_req_ready   = 1'b0;
    i_rsp_valid   = 1'b0;
    i_rsp_inst    = '0;
    i_out_ready   = 1'b0;
  endtask

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [63:0] rand_target();
    logic [63:0] t;
    t = {$urandom, $urandom};
    if ($urandom_range(0, 7) == 0) t = 64'hFFFF_FFFF_FFFF_FFF0;
    if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
    else                           t[1:0] = 2'($urandom_range(1, 3));
    return t;
  endfunction

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (o_req_valid !== 1'b0) $display("FAIL rst_req_valid got %0b want 0", o_req_valid); else n_pass++;
    n_checks++; if (o_out_valid !== 1'b0) $display("FAIL rst_out_valid got %0b want 0", o_out_valid); else n_pass++;
    n_checks++; if (o_misalign !== 1'b0) $display("FAIL rst_misalign got %0b want 0", o_misalign); else n_pass++;
    n_checks++; if (o_out_pc !== '0 || o_out_inst !== '0 || o_misalign_pc !== '0)
      $display("FAIL rst_data got pc=%h inst=%h mpc=%h want zeros", o_out_pc, o_out_inst, o_misalign_pc); else n_pass++;
    n_checks++; if (o_req_addr !== RST_PC) $display("FAIL rst_addr got %h want %h", o_req_addr, RST_PC); else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++; if (o_req_valid !== 1'b1) $display("FAIL first_req_valid got %0b want 1", o_req_valid); else n_pass++;
    n_checks++; if (o_req_addr !== RST_PC) $display("FAIL first_req_addr got %h want %h", o_req_addr, RST_PC); else n_pass++;
  endtask

  task automatic test_basic_fetch();
    i_req_ready = 1'b1;
    tick();
    i_req_ready = 1'b0;
    i_rsp_valid = 1'b1;
    i_rsp_inst  = 32'h0000_0013;
    tick();
    i_rsp_valid = 1'b0;
    n_checks++; if (o_out_valid !== 1'b1) $display("FAIL basic_out_valid got %0b want 1", o_out_valid); else n_pass++;
    n_checks++; if (o_out_pc !== RST_PC) $display("FAIL basic_out_pc got %h want %h", o_out_pc, RST_PC); else n_pass++;
    n_checks++; if (o_out_inst !== 32'h0000_0013) $display("FAIL basic_out_inst got %h want 00000013", o_out_inst); else n_pass++;
    i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0;
    n_checks++; if (o_req_valid !== 1'b1 || o_req_addr !== 64'h8000_0004)
      $display("FAIL basic_next_req got v=%0b a=%h want v=1 a=80000004", o_req_valid, o_req_addr); else n_pass++;
  endtask

  task automatic test_decode_stall();
    i_req_ready = 1'b1;
    tick();
    i_req_ready = 1'b0;
    i_rsp_valid = 1'b1;
    i_rsp_inst  = 32'hCAFE_0093;
    tick();
    i_rsp_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++; if (o_out_valid !== 1'b1 || o_out_pc !== 64'h8000_0004 || o_out_inst !== 32'hCAFE_0093 || o_req_valid !== 1'b0)
        $display("FAIL stall_hold cyc=%0d got v=%0b pc=%h inst=%h req=%0b want v=1 pc=80000004 inst=cafe0093 req=0",
                 k, o_out_valid, o_out_pc, o_out_inst, o_req_valid); else n_pass++;
    end
    i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0;
    n_checks++; if (o_req_valid !== 1'b1 || o_req_addr !== 64'h8000_0008)
      $display("FAIL stall_next_req got v=%0b a=%h want v=1 a=80000008", o_req_valid, o_req_addr); else n_pass++;
  endtask

  task automatic test_redirect_in_wait();
    i_req_ready = 1'b1;
    tick();
    i_req_ready = 1'b0;
    i_ex_redir  = 1'b1;
    i_ex_target = 64'h8000_0100;
    tick();
    i_ex_redir = 1'b0;
    tick();
    n_checks++; if (o_req_valid !== 1'b0 || o_out_valid !== 1'b0)
      $display("FAIL drop_idle got req=%0b out=%0b want 0 0", o_req_valid, o_out_valid); else n_pass++;
    i_rsp_valid = 1'b1;
    i_rsp_inst  = 32'hDEAD_BEEF;
    tick();
    i_rsp_valid = 1'b0;
    tick();
    n_checks++; if (o_out_valid !== 1'b0) $display("FAIL drop_stale_out got %0b want 0", o_out_valid); else n_pass++;
    n_checks++; if (o_req_valid !== 1'b1 || o_req_addr !== 64'h8000_0100)
      $display("FAIL drop_next_req got v=%0b a=%h want v=1 a=80000100", o_req_valid, o_req_addr); else n_pass++;
  endtask

  task automatic test_trap_priority();
    i_ex_redir    = 1'b1;
    i_ex_target   = 64'h8000_0200;
    i_trap_redir  = 1'b1;
    i_trap_target = 64'h8000_0400;
    tick();
    i_ex_redir   = 1'b0;
    i_trap_redir = 1'b0;
    n_checks++; if (o_req_valid !== 1'b1 || o_req_addr !== 64'h8000_0400)
      $display("FAIL prio_req got v=%0b a=%h want v=1 a=80000400", o_req_valid, o_req_addr); else n_pass++;
  endtask

  task automatic test_misalign();
    i_ex_redir  = 1'b1;
    i_ex_target = 64'h8000_0102;
    tick();
    i_ex_redir = 1'b0;
    n_checks++; if (o_misalign !== 1'b1 || o_misalign_pc !== 64'h8000_0102)
      $display("FAIL mis_pulse got m=%0b pc=%h want m=1 pc=80000102", o_misalign, o_misalign_pc); else n_pass++;
    n_checks++; if (o_req_valid !== 1'b1 || o_req_addr !== 64'h8000_0400)
      $display("FAIL mis_unchanged got v=%0b a=%h want v=1 a=80000400", o_req_valid, o_req_addr); else n_pass++;
    tick();
    n_checks++; if (o_misalign !== 1'b0) $display("FAIL mis_one_cycle got %0b want 0", o_misalign); else n_pass++;
  endtask

  task automatic test_wrap_and_reset();
    i_ex_redir  = 1'b1;
    i_ex_target = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    i_ex_redir  = 1'b0;
    i_req_ready = 1'b1;
    tick();
    i_req_ready = 1'b0;
    i_rsp_valid = 1'b1;
    i_rsp_inst  = 32'h1234_5678;
    tick();
    i_rsp_valid = 1'b0;
    n_checks++; if (o_out_pc !== 64'hFFFF_FFFF_FFFF_FFFC || o_out_inst !== 32'h1234_5678)
      $display("FAIL wrap_out got pc=%h inst=%h want fffffffffffffffc 12345678", o_out_pc, o_out_inst); else n_pass++;
    i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0;
    n_checks++; if (o_req_valid !== 1'b1 || o_req_addr !== 64'h0)
      $display("FAIL wrap_next_req got v=%0b a=%h want v=1 a=0", o_req_valid, o_req_addr); else n_pass++;
    i_req_ready = 1'b1;
    tick();
    i_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    n_checks++; if (o_out_valid !== 1'b0 || o_req_valid !== 1'b0 || o_req_addr !== RST_PC)
      $display("FAIL midrst got out=%0b req=%0b a=%h want 0 0 %h", o_out_valid, o_req_valid, o_req_addr, RST_PC); else n_pass++;
    rst         = 1'b0;
    i_rsp_valid = 1'b1;
    i_rsp_inst  = 32'hBAD0_BAD0;
    tick();
    tick();
    i_rsp_valid = 1'b0;
    n_checks++; if (o_req_valid !== 1'b1 || o_out_valid !== 1'b0 || o_req_addr !== RST_PC)
      $display("FAIL midrst_stale got req=%0b out=%0b a=%h want 1 0 %h", o_req_valid, o_out_valid, o_req_addr, RST_PC); else n_pass++;
  endtask

  task automatic test_random();
    logic [63:0] exp_pc, pend_addr, tgt, exp_mis_pc;
    logic        pend, exp_mis, req_fire, out_fire;
    int          cnt, delivered;
    clear_inputs();
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    exp_pc     = RST_PC;
    pend       = 1'b0;
    pend_addr  = '0;
    cnt        = 0;
    exp_mis    = 1'b0;
    exp_mis_pc = '0;
    delivered  = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      n_checks++; if (o_misalign !== exp_mis) $display("FAIL rnd_misalign cyc=%0d got %0b want %0b", cyc, o_misalign, exp_mis); else n_pass++;
      if (exp_mis) begin
        n_checks++; if (o_misalign_pc !== exp_mis_pc)
          $display("FAIL rnd_misalign_pc cyc=%0d got %h want %h", cyc, o_misalign_pc, exp_mis_pc); else n_pass++;
      end
      i_req_ready   = ($urandom_range(0, 3) != 0);
      i_out_ready   = ($urandom_range(0, 3) != 0);
      i_rsp_valid   = pend && (cnt == 0);
      i_rsp_inst    = i_rsp_valid ? inst_of(pend_addr) : $urandom;
      i_ex_redir    = ($urandom_range(0, 31) == 0);
      i_trap_redir  = ($urandom_range(0, 63) == 0);
      i_ex_target   = rand_target();
      i_trap_target = rand_target();
      req_fire = o_req_valid && i_req_ready;
      out_fire = o_out_valid && i_out_ready;
      if (req_fire) begin
        n_checks++; if (o_req_addr !== exp_pc) $display("FAIL rnd_req_addr cyc=%0d got %h want %h", cyc, o_req_addr, exp_pc); else n_pass++;
      end
      if (out_fire) begin
        n_checks++; if (o_out_pc !== exp_pc || o_out_inst !== inst_of(exp_pc))
          $display("FAIL rnd_deliver cyc=%0d got pc=%h inst=%h want pc=%h inst=%h", cyc, o_out_pc, o_out_inst, exp_pc, inst_of(exp_pc));
        else n_pass++;
        exp_pc = exp_pc + 64'd4;
        delivered++;
      end
      tgt        = i_trap_redir ? i_trap_target : i_ex_target;
      exp_mis    = (i_ex_redir || i_trap_redir) && (tgt[1:0] != 2'b00);
      exp_mis_pc = tgt;
      if ((i_ex_redir || i_trap_redir) && tgt[1:0] == 2'b00) exp_pc = tgt;
      if (i_rsp_valid) pend = 1'b0;
      if (req_fire) begin
        pend      = 1'b1;
        pend_addr = o_req_addr;
        cnt       = $urandom_range(0, 3);
      end else if (pend && cnt > 0) begin
        cnt--;
      end
      tick();
    end
    clear_inputs();
    n_checks++; if (delivered < 50) $display("FAIL rnd_progress got %0d deliveries want >= 50", delivered); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_basic_fetch();
    test_decode_stall();
    test_redirect_in_wait();
    test_trap_priority();
    test_misalign();
    test_wrap_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
